// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 states, command constants and parity helper
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, STOP, ACK, WAIT_IDLE} tx_state_t;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchroniser for ps2 clk/data plus clock falling-edge detect
module ps2_sync_edge (
  input  logic sys_clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);
  logic [1:0] clk_ff, data_ff;
  logic prev_clk;
  // sync chains idle high so reset never fakes a falling edge
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      prev_clk <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_in};
      data_ff  <= {data_ff[0], data_in};
      prev_clk <= clk_ff[1];
    end
  assign clk_s  = clk_ff[1];
  assign data_s = data_ff[1];
  assign fall   = prev_clk & ~clk_s;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with ACK check and timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [8:0] shift, shift_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic data_oe, data_oe_n;
  logic clk_s, data_s, fall, timed_out, counting;
  ps2_sync_edge u_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clk_in  (ps2_clk_in),
    .data_in (ps2_data_in),
    .clk_s   (clk_s),
    .data_s  (data_s),
    .fall    (fall)
  );
  assign timed_out   = cnt == CW'(TIMEOUT_CYCLES);
  assign counting    = state inside {REQ, DATA, STOP, ACK, WAIT_IDLE};
  assign tx_ready    = state == IDLE;
  assign busy        = ~tx_ready;
  assign ps2_clk_oe  = state == INHIBIT;
  assign ps2_data_oe = data_oe;
  // state register; reset drops data_oe at once and IDLE releases clk_oe
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      bit_cnt <= '0;
      data_oe <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      data_oe <= data_oe_n;
    end
  // next state: each device clock fall shifts the next frame bit onto the line
  always_comb begin
    state_n   = state;
    cnt_n     = timed_out ? cnt : cnt + 1'b1;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    data_oe_n = data_oe;
    tx_done   = 1'b0;
    tx_err    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n     = '0;
        data_oe_n = 1'b0;
        if (tx_valid) begin
          shift_n = {odd_parity(tx_data), tx_data};
          state_n = INHIBIT;
        end
      end
      INHIBIT:
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_n     = '0;
          data_oe_n = 1'b1;
          state_n   = REQ;
        end
      REQ:
        if (fall) begin
          cnt_n     = '0;
          data_oe_n = ~shift[0];
          shift_n   = shift >> 1;
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      DATA:
        if (fall) begin
          cnt_n     = '0;
          data_oe_n = ~shift[0];
          shift_n   = shift >> 1;
          bit_cnt_n = bit_cnt + 1'b1;
          state_n   = bit_cnt == 4'd7 ? STOP : DATA;
        end
      STOP:
        if (fall) begin
          cnt_n     = '0;
          data_oe_n = 1'b0;
          state_n   = ACK;
        end
      ACK:
        if (fall) begin
          cnt_n   = '0;
          tx_err  = data_s;
          state_n = data_s ? IDLE : WAIT_IDLE;
        end
      WAIT_IDLE:
        if (clk_s && data_s) begin
          tx_done = 1'b1;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
    if (counting && timed_out && state_n != IDLE) begin
      cnt_n     = '0;
      data_oe_n = 1'b0;
      tx_err    = 1'b1;
      state_n   = IDLE;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: fake PS/2 device on a wired-AND bus driving ps2_host_tx
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH = 100;
  localparam int TO  = 20000;
  localparam int H   = 20;
  logic sys_clk = 1'b0, rst = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic bus_clk, bus_data;
  logic pulse_ready = 1'b1;
  int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;
  assign bus_clk  = dev_clk & ~ps2_clk_oe;
  assign bus_data = dev_data & ~ps2_data_oe;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (bus_clk),
    .ps2_data_in (bus_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );
  always #10 sys_clk = ~sys_clk;
  // pulse counters and ready level seen during each pulse
  always @(negedge sys_clk) begin
    done_cnt <= done_cnt + int'(tx_done);
    err_cnt  <= err_cnt + int'(tx_err);
    if (tx_done || tx_err) pulse_ready <= tx_ready;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  // reference frame as seen by the device: start, data LSB first, odd parity, stop
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2) == 0;
    return {1'b1, par, d, 1'b0};
  endfunction
  task automatic send(input logic [7:0] d, input bit hold, output int low);
    @(negedge sys_clk);
    tx_data  = d;
    tx_valid = 1'b1;
    check("ready_before_send", tx_ready, 1'b1);
    @(negedge sys_clk);
    if (hold) tx_data = ~d;
    else tx_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    low = 0;
    for (int i = 0; i < INH * 4 && !ps2_data_oe; i++) begin
      if (!bus_clk) low++;
      @(negedge sys_clk);
    end
    if (hold) begin
      check("ready_low_while_busy", tx_ready, 1'b0);
      tx_valid = 1'b0;
    end
  endtask
  task automatic device(input int nclk, input bit ack, output logic [10:0] fr);
    int w;
    fr = '1;
    w = 0;
    while (!(bus_clk && !bus_data) && w < 2000) begin
      @(negedge sys_clk);
      w++;
    end
    check("device_start_seen", w < 2000, 1'b1);
    repeat (5) @(negedge sys_clk);
    fr[0] = bus_data;
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (H) @(negedge sys_clk);
      dev_clk = 1'b1;
      if (i <= 10) fr[i] = bus_data;
      repeat (H) @(negedge sys_clk);
      if (i == 11) dev_data = 1'b1;
    end
  endtask
  task automatic finish_check(input int d0, input int e0, input int exp_done, input int exp_err);
    int n;
    n = 0;
    while ((done_cnt - d0) + (err_cnt - e0) == 0 && n < TO * 2) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (5) @(negedge sys_clk);
    check("done_pulses", done_cnt - d0, exp_done);
    check("err_pulses", err_cnt - e0, exp_err);
    check("ready_at_pulse", pulse_ready, 1'b0);
    check("ready_after", tx_ready, 1'b1);
    check("clk_oe_released", ps2_clk_oe, 1'b0);
    check("data_oe_released", ps2_data_oe, 1'b0);
  endtask
  task automatic xfer(input logic [7:0] d, input bit ack, input bit hold);
    int d0, e0, low;
    logic [10:0] fr, exp_fr;
    d0 = done_cnt;
    e0 = err_cnt;
    send(d, hold, low);
    check("inhibit_len_ok", low >= INH, 1'b1);
    device(11, ack, fr);
    exp_fr = frame_of(d);
    check("device_frame", fr, exp_fr);
    finish_check(d0, e0, ack ? 1 : 0, ack ? 0 : 1);
  endtask
  initial begin
    int d0, e0, low, n;
    logic [10:0] fr, exp_fr;
    logic [7:0] rd;
    bit rack;
    repeat (3) @(negedge sys_clk);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_err", tx_err, 1'b0);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    xfer(PS2_CMD_SET_LED, 1'b1, 1'b0);
    xfer(8'h01, 1'b1, 1'b0);
    xfer(PS2_CMD_RESET, 1'b1, 1'b0);
    xfer(PS2_CMD_RESET, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rd   = 8'($urandom_range(0, 255));
      rack = 1'($urandom_range(0, 1));
      xfer(rd, rack, 1'b0);
    end
    d0 = done_cnt;
    e0 = err_cnt;
    send(PS2_CMD_ENABLE, 1'b0, low);
    n = 0;
    while (!tx_err && n < TO * 2) begin
      @(negedge sys_clk);
      n++;
    end
    check("timeout_latency_ok", n >= TO - 2 && n <= TO + 2, 1'b1);
    finish_check(d0, e0, 0, 1);
    d0 = done_cnt;
    e0 = err_cnt;
    send(PS2_CMD_ENABLE, 1'b0, low);
    device(4, 1'b1, fr);
    exp_fr = frame_of(PS2_CMD_ENABLE);
    check("partial_frame", fr[4:0], exp_fr[4:0]);
    repeat (3) @(negedge sys_clk);
    check("data_oe_before_rst", ps2_data_oe, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_mid_data_oe", ps2_data_oe, 1'b0);
    check("rst_mid_idle", tx_ready, 1'b1);
    @(negedge sys_clk);
    rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_err", err_cnt - e0, 0);
    xfer(PS2_CMD_ENABLE, 1'b1, 1'b0);
    xfer(PS2_CMD_SET_LED, 1'b1, 1'b1);
    repeat (5) @(negedge sys_clk);
    check("idle_after_hold", busy, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
